// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Multi-channel push-button conditioner. Each channel runs a raw board key
// through a 2-flop synchroniser, normalises it to pressed = 1, and accepts a
// new level only after the synchronised value has disagreed with the current
// output for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle during
// the count abandons it.
//
// Parameters
//   NUM_BTN          number of independent channels
//   DEBOUNCE_CYCLES  consecutive mismatch cycles needed to accept a change (>= 2)
//   ACTIVE_LOW       1: raw key reads 0 when pressed
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-low reset
//   i_btn_raw    raw asynchronous key pins, one bit per channel
//   o_btn_level  debounced level, 1 = pressed (registered)
//   o_btn_rise   one-cycle strobe when o_btn_level goes 0->1 (registered)
//   o_btn_fall   one-cycle strobe when o_btn_level goes 1->0 (registered)
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_rise,
  output logic [NUM_BTN-1:0] o_btn_fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [NUM_BTN-1:0] norm_s;
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] rise_q,  rise_d;
  logic [NUM_BTN-1:0] fall_q,  fall_d;
  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];

  // Polarity normalisation ahead of the first synchroniser flop.
  assign norm_s = i_btn_raw ^ {NUM_BTN{POL}};

  // Next-state logic: synchroniser shift plus per-channel debounce FSM.
  always_comb begin
    sync1_d = norm_s;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = {NUM_BTN{1'b0}};
    fall_d  = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != level_q[i]) begin
            state_d[i] = ST_CHECK;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = CNT_ZERO;
          end
        end
        ST_CHECK: begin
          if (sync2_q[i] == level_q[i]) begin
            // Bounced back before the count completed: abandon it.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_LAST) begin
            // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = CNT_ZERO;
            level_d[i] = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // State register for all channels; reset clears everything, strobes included.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= {NUM_BTN{1'b0}};
      sync2_q <= {NUM_BTN{1'b0}};
      level_q <= {NUM_BTN{1'b0}};
      rise_q  <= {NUM_BTN{1'b0}};
      fall_q  <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign o_btn_level = level_q;
  assign o_btn_rise  = rise_q;
  assign o_btn_fall  = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce (NUM_BTN=2, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1). Stimulus pushes each expected strobe event (cycle, level,
// rise, fall) into a queue; a monitor pops one entry whenever the DUT shows a
// strobe and compares. Inputs change on the falling edge; a raw change driven
// at cycle n reaches sync1 at edge n+1 and is accepted at edge n+6.
// ---------------------------------------------------------------------------
module tb_button_debounce;

  localparam int NB  = 2;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] lvl;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;

  int   cyc    = 0;
  int   errs   = 0;
  int   checks = 0;
  exp_t q[$];

  button_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_raw  (raw),
    .o_btn_level(lvl),
    .o_btn_rise (rise),
    .o_btn_fall (fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    e.cyc  = c;
    e.lvl  = l;
    e.rise = r;
    e.fall = f;
    q.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every cycle that shows a strobe must match the next expected event.
  always @(negedge clk) begin
    if ((rise | fall) !== 2'b00) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_strobe: got lvl=%b rise=%b fall=%b expected no strobe (cycle %0d)",
                 lvl, rise, fall, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_event",
            {cyc[15:0], 2'b00, lvl, 2'b00, rise, 2'b00, fall},
            {e.cyc[15:0], 2'b00, e.lvl, 2'b00, e.rise, 2'b00, e.fall});
      end
    end
  end

  initial begin
    int         c;
    int         d;
    logic [9:0] seq;

    // Reset held with both keys pressed.
    rst = 1'b0;
    raw = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_level", {30'd0, lvl}, 32'd0);
    chk("reset_rise",  {30'd0, rise}, 32'd0);
    chk("reset_fall",  {30'd0, fall}, 32'd0);

    // Release reset with keys still held: fresh press after full latency.
    rst = 1'b1;
    c = cyc;
    push(c + LAT, 2'b11, 2'b11, 2'b00);
    at(c + LAT - 1);
    chk("reset_exit_not_early", {30'd0, lvl}, 32'd0);
    at(c + LAT + 1);
    chk("reset_exit_rise_one_cycle", {30'd0, rise}, 32'd0);
    chk("reset_exit_level_held", {30'd0, lvl}, 32'd3);

    // Release both.
    raw = 2'b11;
    c = cyc;
    push(c + LAT, 2'b00, 2'b00, 2'b11);
    at(c + LAT + 1);

    // Clean press then release on ch0.
    raw = 2'b10;
    c = cyc;
    push(c + LAT, 2'b01, 2'b01, 2'b00);
    at(c + LAT + 1);
    chk("clean_press_rise_drop", {30'd0, rise}, 32'd0);
    at(c + 20);
    raw = 2'b11;
    push(c + 20 + LAT, 2'b00, 2'b00, 2'b01);
    at(c + 20 + LAT + 1);

    // Bounce on ch1: low3 high1 low2 high1 low3, then held low.
    seq = 10'b0001001000;  // bit i = raw1 at step i (LSB first)
    d = 0;
    for (int i = 0; i < 10; i++) begin
      raw[1] = seq[i];
      if (i == 7) begin
        d = cyc;
      end
      @(negedge clk);
    end
    push(d + LAT, 2'b10, 2'b10, 2'b00);
    at(d + LAT - 1);
    chk("bounce_reject_level", {30'd0, lvl}, 32'd0);
    at(d + LAT + 1);
    raw = 2'b11;
    c = cyc;
    push(c + LAT, 2'b00, 2'b00, 2'b10);
    at(c + LAT + 1);

    // Independence: ch0 then ch1 two cycles later.
    raw = 2'b10;
    c = cyc;
    push(c + LAT, 2'b01, 2'b01, 2'b00);
    at(c + 2);
    raw = 2'b00;
    push(c + 2 + LAT, 2'b11, 2'b10, 2'b00);
    at(c + 2 + LAT + 1);
    // Both released and then both pressed on the same edge.
    raw = 2'b11;
    c = cyc;
    push(c + LAT, 2'b00, 2'b00, 2'b11);
    at(c + LAT + 1);
    raw = 2'b00;
    c = cyc;
    push(c + LAT, 2'b11, 2'b11, 2'b00);
    at(c + LAT + 1);

    // Reset mid-count: release ch0, then re-press and reset after 2 counts.
    raw = 2'b01;
    c = cyc;
    push(c + LAT, 2'b10, 2'b00, 2'b01);
    at(c + LAT + 1);
    raw = 2'b00;
    c = cyc;
    at(c + 4);
    rst = 1'b0;
    #1;
    chk("midreset_async_level", {30'd0, lvl}, 32'd0);
    chk("midreset_async_strobes", {28'd0, rise, fall}, 32'd0);
    at(c + 7);
    rst = 1'b1;
    c = cyc;
    push(c + LAT, 2'b11, 2'b11, 2'b00);
    at(c + LAT - 1);
    chk("midreset_full_recount", {30'd0, lvl}, 32'd0);
    at(c + LAT + 1);

    // Boundary: release both, then 3-cycle and 4-cycle presses on ch0.
    raw = 2'b11;
    c = cyc;
    push(c + LAT, 2'b00, 2'b00, 2'b11);
    at(c + LAT + 1);
    raw = 2'b10;
    c = cyc;
    at(c + 3);
    raw = 2'b11;
    at(c + 10);
    chk("boundary_3_cycles_no_change", {30'd0, lvl}, 32'd0);
    raw = 2'b10;
    d = cyc;
    push(d + LAT, 2'b01, 2'b01, 2'b00);
    push(d + 4 + LAT, 2'b00, 2'b00, 2'b01);
    at(d + 4);
    raw = 2'b11;
    at(d + 4 + LAT + 2);

    chk("all_expected_events_seen", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Multi-channel push-button conditioner that sits directly upstream of the button press detector in the FIR/IIR waveform-generator control path. Each channel synchronises a raw, bouncing board key into `i_clk`, normalises its polarity, and releases a new level only after the input has held that level for a programmable number of consecutive cycles. The clean per-channel level drives the press detector's `i_button`. Registered one-cycle rise and fall strobes are provided for consumers that need them directly.

## Interface
- `NUM_BTN`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means the raw key reads 0 when pressed; all outputs use pressed = 1 regardless.
- `i_clk`, in, 1: the single clock; all state is on its rising edge.
- `i_rst`, in, 1: reset, asynchronous and active-low.
- `i_btn_raw`, in, NUM_BTN: raw asynchronous key pins, one bit per channel.
- `o_btn_level`, out, NUM_BTN: debounced level, 1 = pressed; registered.
- `o_btn_rise`, out, NUM_BTN: one-cycle strobe on the same edge `o_btn_level` goes 0→1; registered.
- `o_btn_fall`, out, NUM_BTN: one-cycle strobe on the same edge `o_btn_level` goes 1→0; registered.

## Operation
- All channels are identical and fully independent; no shared counter.
- Synchroniser per channel: two flip-flops, `sync1` then `sync2`.
  - `sync1` samples `i_btn_raw` XOR `ACTIVE_LOW`, so the synchronised value is already normalised to pressed = 1.
- Counter per channel:
  - Width is ceil(log2(DEBOUNCE_CYCLES)), with a minimum of 1.
  - Unsigned; it never wraps, because it is cleared before it can exceed DEBOUNCE_CYCLES−1.
- Per-channel state machine, two states:
  - STABLE: `sync2` == `o_btn_level`; counter held at 0. On `sync2` != `o_btn_level`, go to CHECK with counter ← 1.
  - CHECK, while `sync2` == `o_btn_level` (a bounce back): counter ← 0 and return to STABLE. No output change.
  - CHECK, while `sync2` != `o_btn_level` and counter < DEBOUNCE_CYCLES−1: counter increments.
  - CHECK, while `sync2` != `o_btn_level` and counter == DEBOUNCE_CYCLES−1: on this edge `o_btn_level` ← `sync2`, the matching rise/fall strobe ← 1, counter ← 0, and the state returns to STABLE.
- Strobes are 0 on every edge other than an accepted level update. A strobe therefore never lasts longer than one cycle.
- A mismatch run shorter than DEBOUNCE_CYCLES cycles, including any run interrupted by even a single matching cycle, produces no output change.
- Reset, asserted at any time including mid-count:
  - Asynchronously forces `sync1`, `sync2`, `o_btn_level`, `o_btn_rise`, `o_btn_fall` and the counter to 0, and the state to STABLE.
  - No strobe is emitted on reset entry or exit.
- A key held pressed through reset release is reported as a fresh press after the full latency, with `o_btn_rise` asserted.
- Simultaneous changes on several channels are each reported on their own schedule. Multiple strobe bits may be high on the same cycle.

## Timing
- Reset values: `o_btn_level` = 0, `o_btn_rise` = 0, `o_btn_fall` = 0 on every channel.
- Latency: if the normalised raw value first reaches `sync1` at edge k and stays constant, `o_btn_level` and the strobe update at edge k+1+DEBOUNCE_CYCLES.
  - This is the 2-flop synchroniser plus exactly DEBOUNCE_CYCLES mismatch edges.
- Minimum accepted pulse width: DEBOUNCE_CYCLES consecutive cycles as seen at `sync2`.
- Downstream press detector: registers `o_btn_level` and reports a press one edge later.
- No combinational path from `i_btn_raw` to any output.

## Test plan
All scenarios use NUM_BTN = 2, DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1.
- **Reset:** hold `i_rst` = 0 with `i_btn_raw` = 2'b00 (both pressed). Required: all outputs 0 while reset is asserted. After release, `o_btn_level` = 2'b11 at edge 5 after release, with `o_btn_rise` = 2'b11 for exactly that one cycle.
- **Clean press and release on ch0:** drive raw0 low, first sampled at edge 0. Required: level0 = 1 and rise0 = 1 at edge 5; rise0 = 0 at edge 6. Drive raw0 high at edge 20. Required: level0 = 0 and fall0 = 1 at edge 25.
- **Bounce rejection on ch1:** toggle raw1 as low 3 cycles, high 1, low 2, high 1, low 3. Required: level1 stays 0 and no strobes. Then hold raw1 low. Required: level1 = 1 exactly 4 mismatch cycles after the last bounce is seen at `sync2`.
- **Independence:** press ch0 and ch1 two cycles apart. Required: rise0 and rise1 fire two cycles apart. Press both on the same edge. Required: `o_btn_rise` = 2'b11 on one cycle.
- **Reset mid-count:** start a press on ch0 and assert `i_rst` after 2 counting cycles. Required: outputs 0 immediately, asynchronously. After release, level0 rises only a full 1+4 cycles later, not 2.
- **Boundary:** mismatch lasting exactly 3 cycles. Required: no change. Exactly 4 cycles, then back. Required: level toggles, and a later change back goes through the same 4-cycle counting.
